// File: rtl/hp_bars_pkg.sv
// Shared colours, HUD geometry and per-player state for the two-player health bars.
package hp_bars_pkg;

  localparam int ST_W = 16;
  localparam int FL_W = 8;
  localparam int CW   = ST_W + 1;

  localparam logic [11:0] COL_FRAME  = 12'hFF0;
  localparam logic [11:0] COL_GHOST  = 12'hF80;
  localparam logic [11:0] COL_HEALTH = 12'hF00;
  localparam logic [11:0] COL_FLASH  = 12'hFFF;

  localparam logic [CW-1:0] FRAME_X0    = CW'(3);
  localparam logic [CW-1:0] FRAME_X1    = CW'(1020);
  localparam logic [CW-1:0] FRAME_Y0    = CW'(3);
  localparam logic [CW-1:0] FRAME_Y1    = CW'(29);
  localparam logic [CW-1:0] BAR_Y0      = CW'(6);
  localparam logic [CW-1:0] BAR_Y1      = CW'(26);
  localparam logic [CW-1:0] CAT_X_END   = CW'(508);
  localparam logic [CW-1:0] DOG_X_START = CW'(516);

  typedef struct packed {
    logic [ST_W-1:0] health;
    logic [ST_W-1:0] ghost;
    logic [FL_W-1:0] flash;
    logic            ko;
  } player_t;

  function automatic logic in_span(input logic [CW-1:0] v, input logic [CW-1:0] lo,
                                   input logic [CW-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Cat bar grows leftwards from CAT_X_END; written without subtraction so it never wraps.
  function automatic logic cat_span(input logic [CW-1:0] x, input logic [CW-1:0] len);
    return (x < CAT_X_END) && ((x + len) >= CAT_X_END);
  endfunction

  function automatic logic dog_span(input logic [CW-1:0] x, input logic [CW-1:0] len);
    return (x >= DOG_X_START) && (x < (DOG_X_START + len));
  endfunction

endpackage

// File: rtl/vga_if.sv
// Timing and pixel stream bundle passed between video pipeline stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/hp_channel.sv
// One player's health, trailing ghost bar, hit-flash counter and knockout flag.
module hp_channel
  import hp_bars_pkg::*;
#(
  parameter int HEALTH_MAX   = 500,
  parameter int DAMAGE       = 50,
  parameter int HEAL         = 25,
  parameter int GHOST_STEP   = 2,
  parameter int FLASH_FRAMES = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    frame_tick,
  input  logic    hit,
  input  logic    heal,
  input  logic    round_rst,
  output player_t st
);

  localparam logic [ST_W-1:0] MAX_V   = ST_W'(HEALTH_MAX);
  localparam logic [ST_W-1:0] DMG_V   = ST_W'(DAMAGE);
  localparam logic [ST_W-1:0] HEAL_V  = ST_W'(HEAL);
  localparam logic [ST_W-1:0] STEP_V  = ST_W'(GHOST_STEP);
  localparam logic [FL_W-1:0] FLASH_V = FL_W'(FLASH_FRAMES);
  localparam player_t FULL_ST = '{health: MAX_V, ghost: MAX_V, flash: '0, ko: 1'b0};

  player_t         st_q, st_d;
  logic            hit_ok, heal_ok;
  logic [ST_W-1:0] health_n, ghost_base;

  always_comb begin
    st_d       = st_q;
    hit_ok     = hit & ~st_q.ko;
    heal_ok    = heal & ~hit & ~st_q.ko;
    health_n   = st_q.health;
    ghost_base = st_q.ghost;

    if (hit_ok) begin
      health_n = (st_q.health > DMG_V) ? (st_q.health - DMG_V) : '0;
    end else if (heal_ok) begin
      health_n = ((st_q.health + HEAL_V) >= MAX_V) ? MAX_V : (st_q.health + HEAL_V);
    end

    // Ghost drains toward the new health but never sits below it.
    if (frame_tick) begin
      ghost_base = (st_q.ghost >= STEP_V) ? (st_q.ghost - STEP_V) : '0;
    end

    st_d.health = health_n;
    st_d.ghost  = (ghost_base < health_n) ? health_n : ghost_base;
    st_d.ko     = st_q.ko | (st_q.health == '0);

    if (hit_ok) begin
      st_d.flash = FLASH_V;
    end else if (frame_tick && (st_q.flash != '0)) begin
      st_d.flash = st_q.flash - 1'b1;
    end

    if (round_rst) begin
      st_d = FULL_ST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= FULL_ST;
    end else begin
      st_q <= st_d;
    end
  end

  assign st = st_q;

endmodule

// File: rtl/hp_bars_anim.sv
// Two-player health-bar HUD overlaid on a VGA stream with one registered pipeline stage.
module hp_bars_anim
  import hp_bars_pkg::*;
#(
  parameter int HEALTH_MAX   = 500,
  parameter int DAMAGE       = 50,
  parameter int HEAL         = 25,
  parameter int GHOST_STEP   = 2,
  parameter int FLASH_FRAMES = 8,
  parameter int HP_W         = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hit_cat,
  input  logic            hit_dog,
  input  logic            heal_cat,
  input  logic            heal_dog,
  input  logic            round_rst,
  output logic [HP_W-1:0] hp_cat,
  output logic [HP_W-1:0] hp_dog,
  output logic            ko_cat,
  output logic            ko_dog,
  output logic            bar_on,
  vga_if.vga_in           vga_in,
  vga_if.vga_out          vga_out
);

  player_t cat_st, dog_st;
  logic    frame_tick;

  logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d, vblnk_q, vblnk_d;
  logic [11:0] rgb_q, rgb_d;
  logic        bar_on_q, bar_on_d;

  // The registered vblnk doubles as the previous-cycle sample for edge detection.
  assign frame_tick = vga_in.vblnk & ~vblnk_q;

  hp_channel #(
    .HEALTH_MAX(HEALTH_MAX), .DAMAGE(DAMAGE), .HEAL(HEAL),
    .GHOST_STEP(GHOST_STEP), .FLASH_FRAMES(FLASH_FRAMES)
  ) u_cat (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hit(hit_cat),
    .heal(heal_cat), .round_rst(round_rst), .st(cat_st)
  );

  hp_channel #(
    .HEALTH_MAX(HEALTH_MAX), .DAMAGE(DAMAGE), .HEAL(HEAL),
    .GHOST_STEP(GHOST_STEP), .FLASH_FRAMES(FLASH_FRAMES)
  ) u_dog (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hit(hit_dog),
    .heal(heal_dog), .round_rst(round_rst), .st(dog_st)
  );

  logic [CW-1:0] x, y;
  logic          in_frame, in_bar_y, ghost_px, cat_hp_px, dog_hp_px;

  assign x         = CW'(vga_in.hcount);
  assign y         = CW'(vga_in.vcount);
  assign in_frame  = in_span(x, FRAME_X0, FRAME_X1) & in_span(y, FRAME_Y0, FRAME_Y1);
  assign in_bar_y  = in_span(y, BAR_Y0, BAR_Y1);
  assign ghost_px  = in_bar_y & (cat_span(x, CW'(cat_st.ghost)) | dog_span(x, CW'(dog_st.ghost)));
  assign cat_hp_px = in_bar_y & cat_span(x, CW'(cat_st.health));
  assign dog_hp_px = in_bar_y & dog_span(x, CW'(dog_st.health));

  always_comb begin
    hcount_d = vga_in.hcount;
    vcount_d = vga_in.vcount;
    hsync_d  = vga_in.hsync;
    vsync_d  = vga_in.vsync;
    hblnk_d  = vga_in.hblnk;
    vblnk_d  = vga_in.vblnk;
    rgb_d    = vga_in.rgb;
    bar_on_d = in_frame | ghost_px | cat_hp_px | dog_hp_px;
    if (in_frame) rgb_d = COL_FRAME;
    if (ghost_px) rgb_d = COL_GHOST;
    if (cat_hp_px) rgb_d = (cat_st.flash != '0) ? COL_FLASH : COL_HEALTH;
    if (dog_hp_px) rgb_d = (dog_st.flash != '0) ? COL_FLASH : COL_HEALTH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
      bar_on_q <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      rgb_q    <= rgb_d;
      bar_on_q <= bar_on_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = rgb_q;
  assign bar_on         = bar_on_q;

  assign hp_cat = cat_st.health[HP_W-1:0];
  assign hp_dog = dog_st.health[HP_W-1:0];
  assign ko_cat = cat_st.ko;
  assign ko_dog = dog_st.ko;

endmodule

// File: tb/tb_hp_bars_anim.sv
// Directed scoreboard bench for hp_bars_anim: expectations queued at drive time, popped after the edge.
module tb_hp_bars_anim;

  logic       clk = 1'b0;
  logic       rst, hit_cat, hit_dog, heal_cat, heal_dog, round_rst;
  logic [9:0] hp_cat, hp_dog;
  logic       ko_cat, ko_dog, bar_on;

  vga_if vin ();
  vga_if vout ();

  hp_bars_anim dut (
    .clk(clk), .rst(rst), .hit_cat(hit_cat), .hit_dog(hit_dog),
    .heal_cat(heal_cat), .heal_dog(heal_dog), .round_rst(round_rst),
    .hp_cat(hp_cat), .hp_dog(hp_dog), .ko_cat(ko_cat), .ko_dog(ko_dog),
    .bar_on(bar_on), .vga_in(vin), .vga_out(vout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [11:0] BG     = 12'h123;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] ORANGE = 12'hF80;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] WHITE  = 12'hFFF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
    $display("check %-14s observed=%0h expected=%0h", e.tag, obs, e.exp);
  endtask

  task automatic tick();
    vin.vblnk = 1'b1;
    step();
    vin.vblnk = 1'b0;
    step();
  endtask

  task automatic pix_check(input string tag, input int x, input int y, input logic [11:0] exp);
    vin.hcount = 11'(x);
    vin.vcount = 11'(y);
    vin.rgb    = BG;
    push(tag, 32'(exp));
    push({tag, "_on"}, 32'(exp != BG));
    step();
    check(32'(vout.rgb));
    check(32'(bar_on));
  endtask

  initial begin
    rst = 1'b1; hit_cat = 0; hit_dog = 0; heal_cat = 0; heal_dog = 0; round_rst = 0;
    vin.hcount = 11'd77; vin.vcount = 11'd9; vin.hsync = 1; vin.vsync = 1;
    vin.hblnk = 1; vin.vblnk = 0; vin.rgb = 12'hABC;
    push("rst_hp_cat", 500); push("rst_hp_dog", 500);
    push("rst_ko_cat", 0);   push("rst_ko_dog", 0);
    push("rst_hcount", 0);   push("rst_rgb", 0);
    push("rst_hsync", 0);    push("rst_bar_on", 0);
    step();
    step();
    check(32'(hp_cat)); check(32'(hp_dog)); check(32'(ko_cat)); check(32'(ko_dog));
    check(32'(vout.hcount)); check(32'(vout.rgb)); check(32'(vout.hsync)); check(32'(bar_on));
    rst = 1'b0;

    // Passthrough outside the HUD: every field arrives one cycle later unchanged.
    for (int i = 0; i < 6; i++) begin
      vin.hcount = 11'($urandom_range(0, 2000));
      vin.vcount = 11'($urandom_range(100, 600));
      vin.hsync  = 1'($urandom_range(0, 1));
      vin.vsync  = 1'($urandom_range(0, 1));
      vin.hblnk  = 1'($urandom_range(0, 1));
      vin.vblnk  = 1'($urandom_range(0, 1));
      vin.rgb    = 12'($urandom_range(0, 4095));
      push("pt_hcount", 32'(vin.hcount)); push("pt_vcount", 32'(vin.vcount));
      push("pt_hsync", 32'(vin.hsync));   push("pt_vsync", 32'(vin.vsync));
      push("pt_hblnk", 32'(vin.hblnk));   push("pt_vblnk", 32'(vin.vblnk));
      push("pt_rgb", 32'(vin.rgb));       push("pt_bar_on", 0);
      step();
      check(32'(vout.hcount)); check(32'(vout.vcount)); check(32'(vout.hsync));
      check(32'(vout.vsync));  check(32'(vout.hblnk));  check(32'(vout.vblnk));
      check(32'(vout.rgb));    check(32'(bar_on));
    end
    vin.hsync = 0; vin.vsync = 0; vin.hblnk = 0; vin.vblnk = 0;
    step();

    // Hit and heal together: hit wins.
    hit_cat = 1; heal_cat = 1; push("hit_heal_cat", 450); step();
    hit_cat = 0; heal_cat = 0; check(32'(hp_cat));
    pix_check("ghost_57", 57, 10, ORANGE);
    for (int i = 0; i < 25; i++) tick();
    pix_check("drained_57", 57, 10, YELLOW);
    pix_check("drained_58", 58, 10, RED);
    heal_cat = 1; push("heal_475", 475); step(); heal_cat = 0; check(32'(hp_cat));
    pix_check("track_33", 33, 10, RED);
    pix_check("track_32", 32, 10, YELLOW);
    heal_cat = 1; push("heal_500", 500); step(); check(32'(hp_cat));
    push("heal_sat", 500); step(); heal_cat = 0; check(32'(hp_cat));
    pix_check("full_8", 8, 10, RED);
    pix_check("full_7", 7, 10, YELLOW);

    // Five back-to-back hits, then ghost drains 250 px in 125 frames.
    hit_cat = 1;
    for (int k = 1; k <= 5; k++) begin
      push("hit5_cat", 32'(500 - 50 * k));
      step();
      check(32'(hp_cat));
    end
    hit_cat = 0;
    pix_check("ghost500_8", 8, 10, ORANGE);
    pix_check("ghost500_257", 257, 10, ORANGE);
    pix_check("flash_258", 258, 10, WHITE);
    for (int i = 0; i < 124; i++) tick();
    pix_check("ghost252_257", 257, 10, ORANGE);
    pix_check("ghost252_255", 255, 10, YELLOW);
    tick();
    pix_check("ghost250_257", 257, 10, YELLOW);
    pix_check("ghost250_258", 258, 10, RED);

    // Flash lasts exactly FLASH_FRAMES frames after a hit.
    round_rst = 1; push("rr_hp_cat", 500); step(); round_rst = 0; check(32'(hp_cat));
    hit_cat = 1; push("flash_hit", 450); step(); hit_cat = 0; check(32'(hp_cat));
    for (int f = 1; f <= 9; f++) begin
      pix_check((f <= 8) ? "flash_white" : "flash_red", 300, 10, (f <= 8) ? WHITE : RED);
      tick();
    end

    // Frame boundary pixels.
    pix_check("edge_x2", 2, 10, BG);
    pix_check("edge_x1019", 1019, 28, YELLOW);
    pix_check("edge_x1020", 1020, 28, BG);
    pix_check("edge_y29", 600, 29, BG);
    pix_check("edge_y26", 600, 26, YELLOW);
    pix_check("dog_1015", 1015, 25, RED);
    pix_check("dog_1016", 1016, 25, YELLOW);
    pix_check("gap_512", 512, 10, YELLOW);

    // Dog knocked out after ten hits; further hits and heals ignored.
    hit_dog = 1;
    for (int k = 1; k <= 11; k++) begin
      push("hit_dog", (k < 10) ? 32'(500 - 50 * k) : 32'd0);
      step();
      check(32'(hp_dog));
    end
    hit_dog = 0;
    push("ko_dog", 1); check(32'(ko_dog));
    push("ko_cat_clear", 0); check(32'(ko_cat));
    heal_dog = 1; push("heal_ko_dog", 0); step(); heal_dog = 0; check(32'(hp_dog));
    push("ko_dog_hold", 1); check(32'(ko_dog));
    pix_check("dog_ghost_600", 600, 10, ORANGE);

    // Round reset beats a same-cycle hit.
    round_rst = 1; hit_dog = 1;
    push("rr_hp_dog", 500); push("rr_ko_dog", 0);
    step();
    round_rst = 0; hit_dog = 0;
    check(32'(hp_dog)); check(32'(ko_dog));
    pix_check("rr_noflash", 600, 10, RED);

    // Reset in the middle of a flash clears everything.
    hit_cat = 1; push("pre_rst_hit", 450); step(); hit_cat = 0; check(32'(hp_cat));
    rst = 1; step(); rst = 0;
    push("mid_rst_hp", 500); check(32'(hp_cat));
    pix_check("mid_rst_pix", 300, 10, RED);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hp_bars_anim.md
HP_BARS_ANIM -- requirements
Module: hp_bars_anim

Interface
REQ-001 SHALL have parameter HEALTH_MAX, default 500, full health and bar length in pixels.
REQ-002 SHALL have parameter DAMAGE, default 50, health removed per hit.
REQ-003 SHALL have parameter HEAL, default 25, health restored per heal.
REQ-004 SHALL have parameter GHOST_STEP, default 2, ghost-bar drain in pixels per frame.
REQ-005 SHALL have parameter FLASH_FRAMES, default 8, frames the bar flashes after a hit.
REQ-006 SHALL have parameter HP_W, default 10, width of health values; HEALTH_MAX < 2**HP_W.
REQ-007 SHALL have port clk input 1, the single pixel clock.
REQ-008 SHALL have port rst input 1, reset, synchronous and active-high.
REQ-009 SHALL have ports hit_cat, hit_dog input 1, one-cycle damage pulses.
REQ-010 SHALL have ports heal_cat, heal_dog input 1, one-cycle heal pulses.
REQ-011 SHALL have port round_rst input 1, one-cycle pulse restoring both players.
REQ-012 SHALL have ports hp_cat, hp_dog output HP_W, current health.
REQ-013 SHALL have ports ko_cat, ko_dog output 1, knockout flags.
REQ-014 SHALL have port bar_on output 1, set when the registered pixel belongs to the HUD.
REQ-015 SHALL have ports vga_in (vga_if.vga_in) and vga_out (vga_if.vga_out), the timing/pixel stream.

Function
REQ-016 SHALL define frame_tick as a one-cycle pulse on the rising edge of vga_in.vblnk.
REQ-017 SHALL, per player, on hit with ko clear, set health to max(health-DAMAGE,0).
REQ-018 SHALL, per player, on heal with ko clear, set health to min(health+HEAL,HEALTH_MAX).
REQ-019 SHALL give hit priority over heal when both arrive in the same cycle; heal dropped.
REQ-020 SHALL set ko the cycle after health reaches 0 and hold it; while ko, hit and heal ignored.
REQ-021 SHALL keep ghost >= health: on frame_tick, ghost = max(ghost-GHOST_STEP, health); if health rises above ghost, ghost = health the same cycle.
REQ-022 SHALL load flash counter with FLASH_FRAMES on an accepted hit (reload if already running); decrement on frame_tick; saturate at 0.
REQ-023 SHALL, on round_rst, set health and ghost to HEALTH_MAX, flash to 0, ko clear for both players; round_rst overrides same-cycle hit/heal.
REQ-024 SHALL draw frame x in [3,1020), y in [3,29) yellow 12'hFF0.
REQ-025 SHALL draw, in y [6,26): cat ghost x in [508-ghost,508) orange 12'hF80; dog ghost x in [516,516+ghost) orange.
REQ-026 SHALL draw health over ghost: cat x in [508-health,508), dog x in [516,516+health), red 12'hF00, or white 12'hFFF while that player's flash counter is nonzero.
REQ-027 SHALL apply priority health > ghost > frame > vga_in.rgb.
REQ-028 SHALL register all vga_out fields, bar_on and rgb selection: exactly 1 clk latency, timing fields delayed unchanged.
REQ-029 SHALL present hp_* and ko_* directly from state registers.

Reset
REQ-030 SHALL, on rst at clk edge, set health=ghost=HEALTH_MAX, flash=0, ko=0, vga_out fields, bar_on all 0; rst mid-frame or mid-flash aborts all activity.
REQ-031 SHALL give rst priority over every other input.

Structure
REQ-032 SHALL place colour constants, bar/frame geometry and the player state struct (health, ghost, flash, ko) in package hp_bars_pkg.
REQ-033 SHALL implement per-player state in sub-module hp_channel, instantiated twice; top holds frame_tick, drawing and output register.

Verification
REQ-034 5 hits on cat at 1-cycle spacing -> hp_cat 250, ghost 500, then 125 frame_ticks later ghost 250.
REQ-035 11 hits on dog -> hp_dog 0 after 10th, ko_dog=1, 11th and later heal leave hp_dog 0.
REQ-036 hit_cat and heal_cat same cycle from 500 -> hp_cat 450.
REQ-037 hp_cat 450 then heal -> 475, ghost tracks 475 same cycle; heal at 490 -> 500.
REQ-038 hit then pixel (300,10) on frames 1-8 -> rgb 12'hFFF, frame 9 -> 12'hF00; every vga_out field equals vga_in one cycle earlier.
REQ-039 round_rst with simultaneous hit_dog after ko_dog -> hp_dog 500, ko_dog 0, flash 0.
